// File: rtl/countdown_timer.sv
// Pushbutton countdown timer: load SW with KEY[1], start/pause with KEY[2], count shown on LEDR/HEX.
// Optional macro COUNTDOWN_AUTO_RELOAD_EN reloads the loaded value on the terminal tick instead of stopping.
module countdown_timer #(
  parameter int PRESCALE = 50000000,
  parameter int n        = 10
) (
  input  logic         CLOCK_50,
  input  logic         RESET,
  input  logic [n-1:0] SW,
  input  logic [2:0]   KEY,
  output logic [n-1:0] LEDR,
  output logic [6:0]   HEX0,
  output logic [6:0]   HEX1,
  output logic [6:0]   HEX2,
  output logic [6:0]   HEX3,
  output logic [1:0]   o_dbg_state,
  output logic [31:0]  o_dbg_prescale,
  output logic [2:0]   o_dbg_key_prev
);

  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_state_n;
  logic [n-1:0]   r_count;
  logic [n-1:0]   w_count_n;
  logic [PW-1:0]  r_pre;
  logic [PW-1:0]  w_pre_n;
  logic [2:0]     r_key_prev;
  logic           w_load_press;
  logic           w_start_press;
  logic           w_tick;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [n-1:0]   r_reload;
  logic [n-1:0]   w_reload_n;
`endif

  // Falling-edge detect on the active-low buttons.
  assign w_load_press  = ~KEY[1] & r_key_prev[1];
  assign w_start_press = ~KEY[2] & r_key_prev[2];
  assign w_tick        = (r_state == S_RUN) && (r_pre == PW'(PRESCALE - 1));

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_pre      <= '0;
      r_key_prev <= 3'b111;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      r_reload   <= '0;
`endif
    end else begin
      r_state    <= w_state_n;
      r_count    <= w_count_n;
      r_pre      <= w_pre_n;
      r_key_prev <= KEY;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      r_reload   <= w_reload_n;
`endif
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_count_n = r_count;
    w_pre_n   = r_pre;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    w_reload_n = r_reload;
`endif
    if (w_load_press) begin
      // Load wins over a simultaneous start press.
      w_count_n = SW;
      w_pre_n   = '0;
      w_state_n = S_IDLE;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      w_reload_n = SW;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_press && (r_count != '0)) begin
            w_state_n = S_RUN;
            w_pre_n   = '0;
          end
        end
        S_RUN: begin
          if (w_tick) begin
            w_pre_n = '0;
            if (r_count == n'(1)) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
              w_count_n = r_reload;
`else
              w_count_n = '0;
              w_state_n = S_DONE;
`endif
            end else if (r_count != '0) begin
              w_count_n = r_count - n'(1);
            end
          end else begin
            w_pre_n = r_pre + PW'(1);
          end
          // A pause coinciding with the terminal tick still lands in DONE.
          if (w_start_press && (w_state_n != S_DONE)) w_state_n = S_PAUSE;
        end
        S_PAUSE: begin
          if (w_start_press) w_state_n = S_RUN;
        end
        default: ;
      endcase
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  assign LEDR           = r_count;
  assign HEX0           = seg7(r_count[3:0]);
  assign HEX1           = seg7(r_count[7:4]);
  assign HEX2           = seg7({2'b00, r_count[9:8]});
  assign HEX3           = (r_state == S_DONE) ? 7'b0100001 : 7'b1111111;
  assign o_dbg_state    = r_state;
  assign o_dbg_prescale = 32'(r_pre);
  assign o_dbg_key_prev = r_key_prev;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer with PRESCALE=4: load/decode table plus hand-written run/pause/reset sequences.
module tb_countdown_timer;

  localparam int W = 40;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;
  localparam logic [6:0] H3_BLANK = 7'b1111111;
  localparam logic [6:0] H3_D     = 7'b0100001;

  logic        CLOCK_50;
  logic        RESET;
  logic [9:0]  SW;
  logic [2:0]  KEY;
  logic [9:0]  LEDR;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3;
  logic [1:0]  o_dbg_state;
  logic [31:0] o_dbg_prescale;
  logic [2:0]  o_dbg_key_prev;

  int n_checks = 0;
  int n_err    = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [9:0] sw;
    logic [6:0] h0;
    logic [6:0] h1;
    logic [6:0] h2;
  } vec_t;
  vec_t vecs[8];

  countdown_timer #(.PRESCALE(4), .n(10)) dut (
    .CLOCK_50       (CLOCK_50),
    .RESET          (RESET),
    .SW             (SW),
    .KEY            (KEY),
    .LEDR           (LEDR),
    .HEX0           (HEX0),
    .HEX1           (HEX1),
    .HEX2           (HEX2),
    .HEX3           (HEX3),
    .o_dbg_state    (o_dbg_state),
    .o_dbg_prescale (o_dbg_prescale),
    .o_dbg_key_prev (o_dbg_key_prev)
  );

  // clock / reset
  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] exp_seg(input logic [3:0] v);
    logic [6:0] t[16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[v];
  endfunction

  // driver tasks
  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic press(input logic ld, input logic st);
    KEY = {~st, ~ld, 1'b1};
    step();
    KEY = 3'b111;
  endtask

  // scoreboard
  task automatic compare_front(input string nm);
    logic [W-1:0] got;
    logic [W-1:0] e;
    got = {LEDR, o_dbg_state, HEX0, HEX1, HEX2, HEX3};
    e   = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin
      n_err++;
      $display("FAIL %s: got {ledr,state,hex0..3}=%h expected=%h", nm, got, e);
    end
  endtask

  task automatic check_out(input string nm, input logic [9:0] ledr, input logic [1:0] st,
                           input logic [6:0] h3);
    exp_q.push_back({ledr, st, exp_seg(ledr[3:0]), exp_seg(ledr[7:4]),
                     exp_seg({2'b00, ledr[9:8]}), h3});
    compare_front(nm);
  endtask

  task automatic check_pre(input string nm, input int exp);
    n_checks++;
    if (o_dbg_prescale !== 32'(exp)) begin
      n_err++;
      $display("FAIL %s: prescaler=%0d expected=%0d", nm, o_dbg_prescale, exp);
    end
  endtask

  initial begin
    vecs[0] = '{10'h000, 7'b1000000, 7'b1000000, 7'b1000000};
    vecs[1] = '{10'h3FF, 7'b0001110, 7'b0001110, 7'b0110000};
    vecs[2] = '{10'h1A5, 7'b0010010, 7'b0001000, 7'b1111001};
    vecs[3] = '{10'h2C7, 7'b1111000, 7'b1000110, 7'b0100100};
    vecs[4] = '{10'h0B4, 7'b0011001, 7'b0000011, 7'b1000000};
    vecs[5] = '{10'h36E, 7'b0000110, 7'b0000010, 7'b0110000};
    vecs[6] = '{10'h0D9, 7'b0010000, 7'b0100001, 7'b1000000};
    vecs[7] = '{10'h281, 7'b1111001, 7'b0000000, 7'b0100100};

    RESET = 1'b1;
    SW    = 10'd0;
    KEY   = 3'b111;
    #1;
    check_out("reset_outputs", 10'd0, ST_IDLE, H3_BLANK);
    check_pre("reset_prescaler", 0);
    step();
    step();
    RESET = 1'b0;
    step();
    check_out("after_reset_release", 10'd0, ST_IDLE, H3_BLANK);

    // Load/decode table.
    for (int i = 0; i < 8; i++) begin
      SW = vecs[i].sw;
      press(1'b1, 1'b0);
      exp_q.push_back({vecs[i].sw, ST_IDLE, vecs[i].h0, vecs[i].h1, vecs[i].h2, H3_BLANK});
      compare_front($sformatf("load_table[%0d]", i));
      SW = 10'($urandom_range(0, 1023));
      step();
    end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    SW = 10'd2;
    press(1'b1, 1'b0);
    step();
    press(1'b0, 1'b1);
    check_out("auto_start", 10'd2, ST_RUN, H3_BLANK);
    for (int k = 1; k <= 16; k++) begin
      step();
      check_out($sformatf("auto_seq[%0d]", k), ((k / 4) % 2 == 1) ? 10'd1 : 10'd2, ST_RUN, H3_BLANK);
    end
`else
    // Countdown 3,2,1,0 at 4-cycle spacing, ending in DONE.
    SW = 10'd3;
    press(1'b1, 1'b0);
    step();
    press(1'b0, 1'b1);
    check_out("run3_start", 10'd3, ST_RUN, H3_BLANK);
    for (int k = 1; k <= 12; k++) begin
      step();
      check_out($sformatf("run3_cycle[%0d]", k), 10'(3 - k / 4),
                (k == 12) ? ST_DONE : ST_RUN, (k == 12) ? H3_D : H3_BLANK);
    end
    step();
    press(1'b0, 1'b1);
    check_out("done_ignores_start", 10'd0, ST_DONE, H3_D);

    // Asynchronous reset mid-run.
    step();
    SW = 10'd5;
    press(1'b1, 1'b0);
    check_out("load5_from_done", 10'd5, ST_IDLE, H3_BLANK);
    step();
    press(1'b0, 1'b1);
    step();
    step();
    check_out("run5_before_reset", 10'd5, ST_RUN, H3_BLANK);
    #2;
    RESET = 1'b1;
    #1;
    check_out("async_reset_immediate", 10'd0, ST_IDLE, H3_BLANK);
    step();
    RESET = 1'b0;
    step();
    press(1'b0, 1'b1);
    check_out("start_after_reset_ignored", 10'd0, ST_IDLE, H3_BLANK);
    for (int k = 0; k < 5; k++) step();
    check_out("idle_after_reset_holds", 10'd0, ST_IDLE, H3_BLANK);

    // Pause with prescaler at 2, hold, resume.
    SW = 10'd9;
    press(1'b1, 1'b0);
    step();
    press(1'b0, 1'b1);
    step();
    press(1'b0, 1'b1);
    check_out("pause_entered", 10'd9, ST_PAUSE, H3_BLANK);
    check_pre("pause_prescaler", 2);
    for (int k = 0; k < 20; k++) begin
      step();
      check_out($sformatf("pause_hold[%0d]", k), 10'd9, ST_PAUSE, H3_BLANK);
    end
    check_pre("pause_prescaler_held", 2);
    press(1'b0, 1'b1);
    check_out("resume_edge", 10'd9, ST_RUN, H3_BLANK);
    step();
    check_out("resume_plus1", 10'd9, ST_RUN, H3_BLANK);
    step();
    check_out("resume_plus2_tick", 10'd8, ST_RUN, H3_BLANK);

    // Simultaneous load and start while running.
    SW = 10'd6;
    press(1'b1, 1'b1);
    check_out("load_start_same_cycle", 10'd6, ST_IDLE, H3_BLANK);
    for (int k = 0; k < 10; k++) begin
      step();
      check_pre($sformatf("load_start_pre[%0d]", k), 0);
    end
    check_out("load_start_still_idle", 10'd6, ST_IDLE, H3_BLANK);

    // Tick and start in the same cycle: decrement then PAUSE.
    SW = 10'd2;
    press(1'b1, 1'b0);
    step();
    press(1'b0, 1'b1);
    for (int k = 0; k < 3; k++) step();
    press(1'b0, 1'b1);
    check_out("tick_start_pause", 10'd1, ST_PAUSE, H3_BLANK);
    check_pre("tick_start_pre", 0);
    step();
    press(1'b0, 1'b1);
    for (int k = 0; k < 3; k++) step();
    check_out("resumed_before_tick", 10'd1, ST_RUN, H3_BLANK);
    step();
    check_out("resumed_final_tick", 10'd0, ST_DONE, H3_D);

    // Tick and start on the terminal tick: DONE wins.
    step();
    SW = 10'd1;
    press(1'b1, 1'b0);
    step();
    press(1'b0, 1'b1);
    for (int k = 0; k < 3; k++) step();
    press(1'b0, 1'b1);
    check_out("terminal_tick_start_done", 10'd0, ST_DONE, H3_D);

    // Zero load: start is refused.
    step();
    SW = 10'd0;
    press(1'b1, 1'b0);
    step();
    press(1'b0, 1'b1);
    check_out("zero_start_refused", 10'd0, ST_IDLE, H3_BLANK);
    for (int k = 0; k < 4; k++) step();
    check_out("zero_stays_idle", 10'd0, ST_IDLE, H3_BLANK);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
